mdu_ctrl: RTL and testbench

Multiply/divide sequencing unit for the MIPS CPU. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the execute stage, holds the HI/LO architectural registers, and models the multi-cycle latency of the operation with a busy counter. While an operation is in flight it raises a stall request toward the pipeline controller for any instruction that touches HI/LO.

---
 rtl/mdu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: holds HI/LO, computes the result at issue and commits it after a busy countdown.
// Optional MADD (md_op=7) is enabled by defining MDU_MADD_EN; otherwise op 7 is a NOP.
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = (MAX_CYC > 15) ? $clog2(MAX_CYC + 1) : 4;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             busy_q, busy_d;

  logic        is_mul, is_div, is_madd, long_op;
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_a, div_b, uq, ur, q_res, r_res;
  logic        div_signed, neg_q;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    is_mul  = (md_op == OP_MULT) || (md_op == OP_MULTU);
    is_div  = (md_op == OP_DIV)  || (md_op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_madd = (md_op == 3'd7);
`else
    is_madd = 1'b0;
`endif
    long_op = is_mul || is_div || is_madd;
  end

  always_comb begin
    prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    prod_u = {32'b0, src_a} * {32'b0, src_b};
  end

  // One unsigned divider on magnitudes serves both DIV and DIVU; signs are
  // reapplied afterwards, so 0x8000_0000 / -1 naturally yields 0x8000_0000 rem 0.
  always_comb begin
    div_signed = (md_op == OP_DIV);
    div_a      = (div_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    div_b      = (div_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;
    if (div_b == 32'd0) div_b = 32'd1;
    uq         = div_a / div_b;
    ur         = div_a % div_b;
    neg_q      = div_signed && (src_a[31] ^ src_b[31]);
    q_res      = neg_q ? (~uq + 32'd1) : uq;
    r_res      = (div_signed && src_a[31]) ? (~ur + 32'd1) : ur;
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (src_b == 32'd0) begin
          res_hi = src_a;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = r_res;
          res_lo = q_res;
        end
      end
`ifdef MDU_MADD_EN
      3'd7:     {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (long_op) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            cnt_d     = is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            state_d   = S_RUN;
            busy_d    = 1'b1;
          end else if (md_op == OP_MTHI) begin
            hi_d = src_a;
          end else if (md_op == OP_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      S_RUN: begin
        // Commands arriving here are dropped; the pipeline holds them off via stall.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign stall = md_use & (busy_q | (start & long_op));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: hand-computed vectors checked with immediate assertions.
// Drives on the falling edge, samples 1 time unit after the rising edge.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  int n;

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .md_use (md_use),
    .busy   (busy),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'd0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    md_op  = 3'd0;
    src_a  = 32'd0;
    src_b  = 32'd0;
    md_use = 1'b0;

    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    start = 1'b1; md_op = 3'd1; md_use = 1'b1;
    #1;
    check("reset_stall_follows", {31'd0, stall}, 32'd1);
    start = 1'b0; md_op = 3'd0; md_use = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Abort a DIV with reset in its third cycle
    issue(3'd5, 32'hAAAA_5555, 32'd0);
    issue(3'd6, 32'h5555_AAAA, 32'd0);
    check("preload_hi", hi, 32'hAAAA_5555);
    check("preload_lo", lo, 32'h5555_AAAA);
    issue(3'd3, 32'd100, 32'd7);
    check("div_busy_start", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    issue(3'd2, 32'd3, 32'd4);
    wait_idle(n);
    check("multu_cycles", n, 32'd5);
    check("multu_lo", lo, 32'd12);
    check("multu_hi", hi, 32'd0);

    // Signed multiply, with stall while busy
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi_unchanged", hi, 32'd0);
    md_use = 1'b1;
    #1;
    check("stall_busy_use", {31'd0, stall}, 32'd1);
    md_use = 1'b0;
    #1;
    check("stall_busy_nouse", {31'd0, stall}, 32'd0);
    wait_idle(n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd3, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    check("div_negb_lo", lo, 32'hFFFF_FFFD);
    check("div_negb_hi", hi, 32'd1);

    issue(3'd4, 32'd9, 32'd0);
    wait_idle(n);
    check("divu_zero_hi", hi, 32'd9);
    check("divu_zero_lo", lo, 32'hFFFF_FFFF);

    issue(3'd3, 32'hFFFF_FFFB, 32'd0);
    wait_idle(n);
    check("div_zero_hi", hi, 32'hFFFF_FFFB);
    check("div_zero_lo", lo, 32'hFFFF_FFFF);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    issue(3'd4, 32'hFFFF_FFFF, 32'd16);
    wait_idle(n);
    check("divu_lo", lo, 32'h0FFF_FFFF);
    check("divu_hi", hi, 32'd15);

    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    check("multu_big_hi", hi, 32'hFFFF_FFFE);
    check("multu_big_lo", lo, 32'd1);

    // MULTU offered while a DIV runs is stalled and dropped
    issue(3'd3, 32'd100, 32'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1; md_op = 3'd2; src_a = 32'd3; src_b = 32'd4; md_use = 1'b1;
      #1;
      check("stall_drop", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
    end
    start = 1'b0; md_op = 3'd0;
    wait_idle(n);
    check("drop_hi", hi, 32'd2);
    check("drop_lo", lo, 32'd14);
    check("drop_stall_idle", {31'd0, stall}, 32'd0);
    md_use = 1'b0;
    @(posedge clk); #1;
    check("drop_not_queued", {31'd0, busy}, 32'd0);

    issue(3'd5, 32'h1234_5678, 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_lo_kept", lo, 32'd14);

    issue(3'd0, 32'hDEAD_BEEF, 32'd1);
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", hi, 32'h1234_5678);

    // Combinational stall in IDLE depends on the op being a long one
    @(negedge clk);
    start = 1'b1; md_use = 1'b1; md_op = 3'd3;
    #1;
    check("stall_idle_div", {31'd0, stall}, 32'd1);
    md_op = 3'd5;
    #1;
    check("stall_idle_mthi", {31'd0, stall}, 32'd0);
    md_op = 3'd7;
    #1;
`ifdef MDU_MADD_EN
    check("stall_idle_op7", {31'd0, stall}, 32'd1);
`else
    check("stall_idle_op7", {31'd0, stall}, 32'd0);
`endif
    start = 1'b0; md_use = 1'b0; md_op = 3'd0;

    // Back-to-back MULTs; commit edge boundary
    issue(3'd1, 32'd6, 32'd7);
    wait_idle(n);
    check("b2b_first_lo", lo, 32'd42);
    issue(3'd1, 32'd2, 32'd3);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("precommit_busy", {31'd0, busy}, 32'd1);
    check("precommit_lo_old", lo, 32'd42);
    @(posedge clk); #1;
    check("commit_busy", {31'd0, busy}, 32'd0);
    check("commit_lo", lo, 32'd6);
    check("commit_hi", hi, 32'd0);

    // op 7: MADD when enabled, otherwise a NOP
    issue(3'd5, 32'd0, 32'd0);
    issue(3'd6, 32'hFFFF_FFFF, 32'd0);
    issue(3'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    check("madd_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("madd_cycles", n, 32'd5);
    check("madd_hi", hi, 32'd1);
    check("madd_lo", lo, 32'd0);
`else
    check("op7_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    check("op7_busy_later", {31'd0, busy}, 32'd0);
    check("op7_hi", hi, 32'd0);
    check("op7_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
